// File: rtl/lp_filter_scheduler.sv
// Multi-channel cascaded first-order low-pass filter sharing one stage datapath.
// Optional feature: define LP_FILTER_SCHED_PRELOAD_EN to preload a channel's stages from its first sample.
module lp_filter_scheduler #(
  parameter int DATA_BITS     = 28,
  parameter int SHIFT_BITS    = 6,
  parameter int STAGE_COUNT   = 4,
  parameter int CHANNEL_COUNT = 4,
  parameter int CH_BITS       = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CE,
  input  logic                 FLUSH,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [CH_BITS-1:0]   IN_CHANNEL,
  input  logic [DATA_BITS-1:0] IN_VALUE,
  output logic                 OUT_VALID,
  output logic [CH_BITS-1:0]   OUT_CHANNEL,
  output logic [DATA_BITS-1:0] OUT_VALUE,
  output logic                 BUSY
);

  localparam int WORDS     = CHANNEL_COUNT * STAGE_COUNT;
  localparam int ADDR_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int STG_BITS  = (STAGE_COUNT > 1) ? $clog2(STAGE_COUNT) : 1;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RUN, S_OUT} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   clr_addr_q, clr_addr_d;
  logic [STG_BITS-1:0]    stage_q, stage_d;
  logic [CH_BITS-1:0]     ch_q, ch_d;
  logic [DATA_BITS-1:0]   sample_q, sample_d;
  logic [DATA_BITS-1:0]   prev_q, prev_d;
  logic                   pend_q, pend_d;
  logic                   out_valid_q, out_valid_d;
  logic [CH_BITS-1:0]     out_channel_q, out_channel_d;
  logic [DATA_BITS-1:0]   out_value_q, out_value_d;

  logic [DATA_BITS-1:0]   mem [WORDS];
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [DATA_BITS-1:0]   mem_wdata;

  logic [ADDR_BITS-1:0]   run_addr;
  logic                   last_stage;
  logic [DATA_BITS-1:0]   x_in, st_cur, st_new;
  logic signed [DATA_BITS:0] diff, step_v, sum;

`ifdef LP_FILTER_SCHED_PRELOAD_EN
  localparam int CHI_BITS = $clog2(CHANNEL_COUNT);
  logic [CHANNEL_COUNT-1:0] primed_q, primed_d;
  logic [CHI_BITS-1:0]      ch_idx;
  assign ch_idx = ch_q[CHI_BITS-1:0];
`endif

  assign run_addr   = ADDR_BITS'(int'(ch_q) * STAGE_COUNT + int'(stage_q));
  assign last_stage = (stage_q == STG_BITS'(STAGE_COUNT - 1));
  assign st_cur     = mem[run_addr];
  assign x_in       = (stage_q == '0) ? sample_q : prev_q;

  // One smoothing stage: st + ((x - st) >>> SHIFT), difference kept one bit wider so it stays signed.
  always_comb begin
    diff   = $signed({1'b0, x_in}) - $signed({1'b0, st_cur});
    step_v = diff >>> SHIFT_BITS;
    sum    = $signed({1'b0, st_cur}) + step_v;
    st_new = sum[DATA_BITS-1:0];
`ifdef LP_FILTER_SCHED_PRELOAD_EN
    if (!primed_q[ch_idx]) st_new = x_in;
`endif
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    stage_d       = stage_q;
    ch_d          = ch_q;
    sample_d      = sample_q;
    prev_d        = prev_q;
    pend_d        = pend_q;
    out_valid_d   = out_valid_q;
    out_channel_d = out_channel_q;
    out_value_d   = out_value_q;
    mem_we        = 1'b0;
    mem_waddr     = run_addr;
    mem_wdata     = st_new;
`ifdef LP_FILTER_SCHED_PRELOAD_EN
    primed_d      = primed_q;
`endif
    if (CE) begin
      out_valid_d = 1'b0;
      unique case (state_q)
        S_CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = clr_addr_q;
          mem_wdata = '0;
          pend_d    = 1'b0;
          if (clr_addr_q == ADDR_BITS'(WORDS - 1)) begin
            state_d = S_IDLE;
`ifdef LP_FILTER_SCHED_PRELOAD_EN
            primed_d = '0;
`endif
          end else begin
            clr_addr_d = clr_addr_q + ADDR_BITS'(1);
          end
        end
        S_IDLE: begin
          if (FLUSH) begin
            state_d    = S_CLEAR;
            clr_addr_d = '0;
          end else if (IN_VALID && int'(IN_CHANNEL) < CHANNEL_COUNT) begin
            // Out-of-range channels are consumed here without leaving IDLE.
            state_d  = S_RUN;
            stage_d  = '0;
            ch_d     = IN_CHANNEL;
            sample_d = IN_VALUE;
          end
        end
        S_RUN: begin
          mem_we = 1'b1;
          prev_d = st_new;
          if (FLUSH) pend_d = 1'b1;
          if (last_stage) begin
            state_d       = S_OUT;
            out_valid_d   = 1'b1;
            out_value_d   = st_new;
            out_channel_d = ch_q;
`ifdef LP_FILTER_SCHED_PRELOAD_EN
            primed_d[ch_idx] = 1'b1;
`endif
          end else begin
            stage_d = stage_q + STG_BITS'(1);
          end
        end
        S_OUT: begin
          if (pend_q || FLUSH) begin
            state_d    = S_CLEAR;
            clr_addr_d = '0;
            pend_d     = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_CLEAR;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= S_CLEAR;
      clr_addr_q    <= '0;
      stage_q       <= '0;
      ch_q          <= '0;
      sample_q      <= '0;
      prev_q        <= '0;
      pend_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_value_q   <= '0;
`ifdef LP_FILTER_SCHED_PRELOAD_EN
      primed_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      stage_q       <= stage_d;
      ch_q          <= ch_d;
      sample_q      <= sample_d;
      prev_q        <= prev_d;
      pend_q        <= pend_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      out_value_q   <= out_value_d;
`ifdef LP_FILTER_SCHED_PRELOAD_EN
      primed_q      <= primed_d;
`endif
    end
  end

  // NOTE: the state memory has no reset; the CLEAR sweep zeroes it after every reset or flush.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign IN_READY    = (state_q == S_IDLE) && !FLUSH;
  assign BUSY        = (state_q != S_IDLE);
  assign OUT_VALID   = out_valid_q;
  assign OUT_CHANNEL = out_channel_q;
  assign OUT_VALUE   = out_value_q;

endmodule

// File: tb/tb_lp_filter_scheduler.sv
// Directed bench: unit 0 runs STAGE_COUNT=1, unit 1 runs STAGE_COUNT=4, both with 4 channels.
module tb_lp_filter_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]       ce, flush, in_valid, in_ready, out_valid, busy;
  logic [1:0][3:0]  in_channel, out_channel;
  logic [1:0][27:0] in_value, out_value;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lp_filter_scheduler #(.STAGE_COUNT(1)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .CE(ce[0]), .FLUSH(flush[0]),
    .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]), .IN_CHANNEL(in_channel[0]),
    .IN_VALUE(in_value[0]), .OUT_VALID(out_valid[0]), .OUT_CHANNEL(out_channel[0]),
    .OUT_VALUE(out_value[0]), .BUSY(busy[0]));

  lp_filter_scheduler #(.STAGE_COUNT(4)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .CE(ce[1]), .FLUSH(flush[1]),
    .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]), .IN_CHANNEL(in_channel[1]),
    .IN_VALUE(in_value[1]), .OUT_VALID(out_valid[1]), .OUT_CHANNEL(out_channel[1]),
    .OUT_VALUE(out_value[1]), .BUSY(busy[1]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample, wait for acceptance, then count CE cycles until the result strobe.
  // lat is the cycle offset from the acceptance cycle T at which OUT_VALID is seen.
  task automatic send(input int d, input logic [3:0] ch, input logic [27:0] v,
                      output int lat, output logic [27:0] val, output logic [3:0] och);
    int waited = 0;
    in_channel[d] = ch;
    in_value[d]   = v;
    in_valid[d]   = 1'b1;
    #1;
    while (!in_ready[d] && waited < 100) begin
      step();
      waited++;
    end
    step();
    in_valid[d] = 1'b0;
    lat = 1;
    while (!out_valid[d] && lat < 40) begin
      step();
      lat++;
    end
    val = out_value[d];
    och = out_channel[d];
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (busy[d] && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n, na, nb;
    rst_n = 1'b0;
    #3;
    for (int d = 0; d < 2; d++) begin
      checks++; if (out_valid[d] !== 1'b0) begin failures++; $display("FAIL reset_out_valid[%0d]: got %0d expected 0", d, out_valid[d]); end
      checks++; if (out_value[d] !== 28'd0) begin failures++; $display("FAIL reset_out_value[%0d]: got %0d expected 0", d, out_value[d]); end
      checks++; if (out_channel[d] !== 4'd0) begin failures++; $display("FAIL reset_out_channel[%0d]: got %0d expected 0", d, out_channel[d]); end
      checks++; if (busy[d] !== 1'b1) begin failures++; $display("FAIL reset_busy[%0d]: got %0d expected 1", d, busy[d]); end
      checks++; if (in_ready[d] !== 1'b0) begin failures++; $display("FAIL reset_in_ready[%0d]: got %0d expected 0", d, in_ready[d]); end
    end
    step();
    step();
    rst_n = 1'b1;
    n = 0; na = -1; nb = -1;
    while ((na < 0 || nb < 0) && n < 100) begin
      step();
      n++;
      if (na < 0 && in_ready[0]) na = n;
      if (nb < 0 && in_ready[1]) nb = n;
    end
    checks++; if (na !== 4) begin failures++; $display("FAIL clear_len_a: got %0d expected 4", na); end
    checks++; if (nb !== 16) begin failures++; $display("FAIL clear_len_b: got %0d expected 16", nb); end
  endtask

  task automatic test_single_stage();
    int lat; logic [27:0] val; logic [3:0] och;
    send(0, 4'd0, 28'd6400, lat, val, och);
    checks++; if (lat !== 2) begin failures++; $display("FAIL single_lat: got %0d expected 2", lat); end
    checks++; if (val !== 28'd100) begin failures++; $display("FAIL single_value: got %0d expected 100", val); end
    checks++; if (och !== 4'd0) begin failures++; $display("FAIL single_channel: got %0d expected 0", och); end
    step();
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL single_strobe_width: got %0d expected 0", out_valid[0]); end
  endtask

  // Full-scale input through four stages, then two zero samples exercising negative differences.
  task automatic test_full_scale();
    int lat; logic [27:0] val; logic [3:0] och;
    logic [27:0] vin [3];
    logic [27:0] vexp [3];
    vin  = '{28'hFFFFFFF, 28'd0, 28'd0};
    vexp = '{28'd15, 28'd62, 28'd154};
    for (int i = 0; i < 3; i++) begin
      send(1, 4'd3, vin[i], lat, val, och);
      checks++; if (val !== vexp[i]) begin failures++; $display("FAIL full_scale_value[%0d]: got %0d expected %0d", i, val, vexp[i]); end
      checks++; if (och !== 4'd3) begin failures++; $display("FAIL full_scale_channel[%0d]: got %0d expected 3", i, och); end
      checks++; if (lat !== 5) begin failures++; $display("FAIL full_scale_lat[%0d]: got %0d expected 5", i, lat); end
    end
    wait_idle(1);
  endtask

  task automatic test_back_to_back();
    int acc_q[$];
    int last_acc = -1;
    int a;
    logic [27:0] prev_out = 28'd0;
    in_channel[1] = 4'd0;
    in_value[1]   = 28'd1000000;
    in_valid[1]   = 1'b1;
    #1;
    for (int c = 0; c < 62; c++) begin
      if (in_ready[1]) begin
        if (last_acc >= 0) begin
          checks++; if (c - last_acc !== 6) begin failures++; $display("FAIL b2b_gap: got %0d expected 6", c - last_acc); end
        end
        last_acc = c;
        acc_q.push_back(c);
      end
      if (out_valid[1]) begin
        a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
        checks++; if (c - a !== 5) begin failures++; $display("FAIL b2b_lat: got %0d expected 5", c - a); end
        checks++; if (out_value[1] < prev_out || out_value[1] > 28'd1000000) begin
          failures++; $display("FAIL b2b_monotonic: got %0d expected between %0d and 1000000", out_value[1], prev_out);
        end
        prev_out = out_value[1];
      end
      step();
    end
    in_valid[1] = 1'b0;
    wait_idle(1);
  endtask

  task automatic test_interleave();
    int lat; logic [27:0] val; logic [3:0] och;
    logic [27:0] exp1 [4];
    exp1 = '{28'd64, 28'd127, 28'd189, 28'd250};
    for (int i = 0; i < 4; i++) begin
      send(0, 4'd1, 28'd4096, lat, val, och);
      checks++; if (val !== exp1[i] || och !== 4'd1) begin failures++; $display("FAIL interleave_ch1[%0d]: got %0d/ch%0d expected %0d/ch1", i, val, och, exp1[i]); end
      send(0, 4'd2, 28'd0, lat, val, och);
      checks++; if (val !== 28'd0 || och !== 4'd2) begin failures++; $display("FAIL interleave_ch2[%0d]: got %0d/ch%0d expected 0/ch2", i, val, och); end
    end
    wait_idle(0);
  endtask

  task automatic test_flush();
    int lat, n; logic [27:0] val; logic [3:0] och;
    bit strobe;
    // FLUSH in IDLE wins over a simultaneous offer.
    in_channel[0] = 4'd0; in_value[0] = 28'd6400; in_valid[0] = 1'b1; flush[0] = 1'b1;
    #1;
    checks++; if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL flush_idle_ready: got %0d expected 0", in_ready[0]); end
    step();
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    n = 0; strobe = 1'b0;
    while (busy[0] && n < 50) begin
      if (out_valid[0]) strobe = 1'b1;
      n++;
      step();
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL flush_idle_busy: got %0d expected 4", n); end
    checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL flush_idle_strobe: got %0d expected 0", strobe); end
    send(0, 4'd1, 28'd4096, lat, val, och);
    checks++; if (val !== 28'd64) begin failures++; $display("FAIL flush_idle_cleared: got %0d expected 64", val); end
    wait_idle(0);
    // FLUSH during RUN lets the sample finish, then clears.
    in_channel[0] = 4'd0; in_value[0] = 28'd6400; in_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!in_ready[0] && n < 50) begin step(); n++; end
    step();
    in_valid[0] = 1'b0;
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    checks++; if (out_valid[0] !== 1'b1) begin failures++; $display("FAIL flush_run_strobe: got %0d expected 1", out_valid[0]); end
    checks++; if (out_value[0] !== 28'd100) begin failures++; $display("FAIL flush_run_value: got %0d expected 100", out_value[0]); end
    step();
    n = 0;
    while (busy[0] && n < 50) begin n++; step(); end
    checks++; if (n !== 4) begin failures++; $display("FAIL flush_run_busy: got %0d expected 4", n); end
    send(0, 4'd1, 28'd6400, lat, val, och);
    checks++; if (val !== 28'd100) begin failures++; $display("FAIL flush_run_after: got %0d expected 100", val); end
    wait_idle(0);
  endtask

  task automatic test_bad_channel();
    int lat; logic [27:0] val; logic [3:0] och;
    bit strobe = 1'b0;
    in_channel[0] = 4'd15; in_value[0] = 28'd6400; in_valid[0] = 1'b1;
    #1;
    checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL bad_ch_ready: got %0d expected 1", in_ready[0]); end
    step();
    in_valid[0] = 1'b0;
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL bad_ch_busy: got %0d expected 0", busy[0]); end
    for (int i = 0; i < 5; i++) begin
      if (out_valid[0]) strobe = 1'b1;
      step();
    end
    checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL bad_ch_strobe: got %0d expected 0", strobe); end
    send(0, 4'd2, 28'd6400, lat, val, och);
    checks++; if (val !== 28'd100 || och !== 4'd2) begin failures++; $display("FAIL bad_ch_next: got %0d/ch%0d expected 100/ch2", val, och); end
    wait_idle(0);
  endtask

  task automatic test_ce_stall();
    int lat, n;
    in_channel[1] = 4'd1; in_value[1] = 28'hFFFFFFF; in_valid[1] = 1'b1;
    #1;
    n = 0;
    while (!in_ready[1] && n < 50) begin step(); n++; end
    step();
    in_valid[1] = 1'b0;
    lat = 1;
    step(); lat++;
    ce[1] = 1'b0;
    repeat (3) begin step(); lat++; end
    ce[1] = 1'b1;
    while (!out_valid[1] && lat < 40) begin step(); lat++; end
    checks++; if (lat !== 8) begin failures++; $display("FAIL ce_stall_lat: got %0d expected 8", lat); end
    checks++; if (out_value[1] !== 28'd15) begin failures++; $display("FAIL ce_stall_value: got %0d expected 15", out_value[1]); end
    ce[1] = 1'b0;
    step();
    checks++; if (out_valid[1] !== 1'b1 || out_value[1] !== 28'd15) begin failures++; $display("FAIL ce_hold_out: got %0d/%0d expected 1/15", out_valid[1], out_value[1]); end
    ce[1] = 1'b1;
    step();
    checks++; if (out_valid[1] !== 1'b0) begin failures++; $display("FAIL ce_release_out: got %0d expected 0", out_valid[1]); end
    wait_idle(1);
  endtask

  task automatic test_reset_mid_run();
    int lat, n, nb; logic [27:0] val; logic [3:0] och;
    bit strobe = 1'b0;
    in_channel[1] = 4'd2; in_value[1] = 28'hFFFFFFF; in_valid[1] = 1'b1;
    #1;
    n = 0;
    while (!in_ready[1] && n < 50) begin step(); n++; end
    step();
    in_valid[1] = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid[1] !== 1'b0 || busy[1] !== 1'b1 || in_ready[1] !== 1'b0) begin
      failures++; $display("FAIL mid_run_reset: got valid=%0d busy=%0d ready=%0d expected 0/1/0", out_valid[1], busy[1], in_ready[1]);
    end
    step();
    rst_n = 1'b1;
    n = 0; nb = -1;
    while (nb < 0 && n < 100) begin
      step();
      n++;
      if (out_valid[1]) strobe = 1'b1;
      if (in_ready[1]) nb = n;
    end
    checks++; if (nb !== 16) begin failures++; $display("FAIL mid_run_clear_len: got %0d expected 16", nb); end
    checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL mid_run_strobe: got %0d expected 0", strobe); end
    send(1, 4'd2, 28'hFFFFFFF, lat, val, och);
    checks++; if (val !== 28'd15) begin failures++; $display("FAIL mid_run_restart: got %0d expected 15", val); end
    wait_idle(1);
    wait_idle(0);
  endtask

  task automatic test_preload();
    int lat; logic [27:0] val; logic [3:0] och;
    logic [27:0] e1, e2;
`ifdef LP_FILTER_SCHED_PRELOAD_EN
    e1 = 28'd5000; e2 = 28'd5001;
`else
    e1 = 28'd78;   e2 = 28'd155;
`endif
    send(0, 4'd3, 28'd5000, lat, val, och);
    checks++; if (val !== e1 || lat !== 2) begin failures++; $display("FAIL preload_first: got %0d lat %0d expected %0d lat 2", val, lat, e1); end
    send(0, 4'd3, 28'd5064, lat, val, och);
    checks++; if (val !== e2) begin failures++; $display("FAIL preload_second: got %0d expected %0d", val, e2); end
    wait_idle(0);
  endtask

  initial begin
    ce = 2'b11; flush = 2'b00; in_valid = 2'b00;
    in_channel = '0; in_value = '0;
    test_reset();
    test_single_stage();
    test_full_scale();
    test_back_to_back();
    test_interleave();
    test_flush();
    test_bad_channel();
    test_ce_stall();
    test_reset_mid_run();
    test_preload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lp_filter_scheduler.md
LP_FILTER_SCHEDULER -- requirements
Module: lp_filter_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 28, meaning sample and filter-state width.
REQ-002 The block SHALL have parameter SHIFT_BITS, default 6, meaning per-stage smoothing shift, with coefficient 2^-SHIFT_BITS.
REQ-003 The block SHALL have parameter STAGE_COUNT, default 4, legal range 1..8, meaning cascaded stages per channel.
REQ-004 The block SHALL have parameter CHANNEL_COUNT, default 4, legal range 2..16, and CH_BITS, default 4, the channel index width.
REQ-005 The block SHALL have these ports, one per line:
 CLK  in  1  single clock, all logic on rising edge
 RESET_N  in  1  asynchronous, active-low reset
 CE  in  1  clock enable; 0 freezes all state
 FLUSH  in  1  request to clear all filter state
 IN_VALID  in  1  sample offered
 IN_READY  out  1  sample accepted when IN_VALID&IN_READY&CE
 IN_CHANNEL  in  CH_BITS  channel of offered sample
 IN_VALUE  in  DATA_BITS  unsigned sample
 OUT_VALID  out  1  one-CE-cycle result strobe
 OUT_CHANNEL  out  CH_BITS  channel of result
 OUT_VALUE  out  DATA_BITS  last-stage filtered value
 BUSY  out  1  high whenever state is not IDLE

Function
REQ-006 The block SHALL time-share one stage datapath across all channels; state memory holds CHANNEL_COUNT*STAGE_COUNT words of DATA_BITS, indexed by channel*STAGE_COUNT+stage.
REQ-007 The FSM SHALL have states CLEAR, IDLE, RUN and OUT, and SHALL advance only in cycles with CE=1.
REQ-008 In CLEAR, the block SHALL zero one state word per cycle at addresses 0..CHANNEL_COUNT*STAGE_COUNT-1, clear all per-channel primed bits, then go to IDLE.
REQ-009 IN_READY SHALL be combinational and equal (state==IDLE)&~FLUSH.
REQ-010 On acceptance, the block SHALL capture IN_VALUE and IN_CHANNEL and go to RUN with stage=0; if IN_CHANNEL>=CHANNEL_COUNT, it SHALL consume the sample, produce no output and remain in IDLE.
REQ-011 In RUN, the block SHALL process one stage per cycle: x = captured sample for stage 0, otherwise the previous stage's new value; d = x-st computed signed in DATA_BITS+1 bits; st' = st+(d>>>SHIFT_BITS) arithmetic, truncated to DATA_BITS; st' written back.
REQ-012 After stage STAGE_COUNT-1, the FSM SHALL go to OUT; in OUT, OUT_VALID=1, OUT_VALUE equals the last st' and OUT_CHANNEL equals the captured channel; the next state is IDLE.
REQ-013 Latency SHALL be fixed: acceptance at CE-cycle T gives OUT_VALID at CE-cycle T+STAGE_COUNT+1; the maximum accept rate is one sample per STAGE_COUNT+2 CE-cycles.
REQ-014 In IDLE, FLUSH=1 SHALL enter CLEAR and take priority over a simultaneous IN_VALID, which is not accepted.
REQ-015 FLUSH asserted in RUN or OUT SHALL set a pending flag; the current sample SHALL complete and OUT SHALL be followed by CLEAR instead of IDLE.
REQ-016 With CE=0, all registers and outputs SHALL hold, including a held OUT_VALID; no handshake occurs.

Reset
REQ-017 RESET_N=0 SHALL asynchronously force state=CLEAR, clear address 0, OUT_VALID=0, OUT_CHANNEL=0, OUT_VALUE=0 and the pending flush flag to 0; BUSY=1 and IN_READY=0 follow from the state.
REQ-018 Reset asserted mid-RUN SHALL abandon the sample with no OUT_VALID; after release, CLEAR SHALL run in full before IN_READY rises.

Configuration
REQ-019 With macro LP_FILTER_SCHED_PRELOAD_EN defined, the first accepted sample on an unprimed channel SHALL write x into all of that channel's stages, output x, and set the primed bit; the cycle timing SHALL be unchanged.
REQ-020 Without LP_FILTER_SCHED_PRELOAD_EN, no primed bits SHALL exist and every sample SHALL use REQ-011, starting from the zeroed state.

Verification
REQ-021 Scenario, macro off, STAGE_COUNT=1: after clear, ch0 sample 6400 -> OUT_VALUE=100, OUT_CHANNEL=0, OUT_VALID at T+2.
REQ-022 Scenario, STAGE_COUNT=4: IN_READY is high every 6th CE cycle under continuous IN_VALID; OUT_VALID is at T+5; OUT_VALUE increases monotonically toward a constant 1000000.
REQ-023 Scenario: interleaved ch1=4096 and ch2=0 -> ch2 outputs stay 0, and the ch1 sequence is identical to a ch1-only run.
REQ-024 Scenario: FLUSH during RUN -> OUT still strobes, BUSY stays high for CHANNEL_COUNT*STAGE_COUNT more cycles, and the next ch1=6400 with STAGE_COUNT=1 -> 100.
REQ-025 Scenario: IN_CHANNEL=15 with CHANNEL_COUNT=4 -> accepted, no OUT_VALID; CE low for 3 cycles during RUN -> latency is extended by exactly 3 cycles.
REQ-026 Scenario, macro on: first ch3 sample 5000 -> OUT_VALUE=5000; a second sample 5064 with STAGE_COUNT=1 -> 5001.
